vec_mem_sequencer: RTL and testbench

- Controller for the vector MEM stage.
- Turns one vector load/store instruction into a sequence of per-element memory requests: computes each element address (base + i*stride), drives the memory write enable and the element index, and stalls the upstream pipeline while it runs.
- For loads, it tracks read latency and flags each returning element for writeback into the vector register file.

---
 rtl/vec_mem_pkg.sv | 14 +
 rtl/vec_lat_pipe.sv | 43 ++++
 rtl/vec_mem_sequencer.sv | 123 ++++++++++++
 tb/tb_vec_mem_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared constants for the vector MEM-stage sequencer: FSM state encoding and default sizes.
package vec_mem_pkg;

    localparam int ADDR_W   = 32;
    localparam int VLEN_MAX = 8;
    localparam int IDX_W    = 3;
    localparam int MEM_LAT  = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/vec_lat_pipe.sv
// Fixed-depth valid+index shift pipeline with synchronous clear; the tail stage is the
// element whose data returns this cycle.
module vec_lat_pipe import vec_mem_pkg::*; #(
    parameter int DEPTH    = MEM_LAT,
    parameter int IDX_BITS = IDX_W
) (
    input  logic                clk,
    input  logic                clear_i,
    input  logic                push_vld_i,
    input  logic [IDX_BITS-1:0] push_idx_i,
    output logic                out_vld_o,
    output logic [IDX_BITS-1:0] out_idx_o,
    output logic                pending_o
);

    logic [DEPTH-1:0]    vld_q;
    logic [IDX_BITS-1:0] idx_q [DEPTH];

    // NOTE: the index array is cleared too, so wb_idx reads 0 after reset instead of stale lanes.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= push_vld_i;
            idx_q[0] <= push_vld_i ? push_idx_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_vld_o = vld_q[DEPTH-1];
    assign out_idx_o = idx_q[DEPTH-1];

    // Entries still in flight after this cycle's tail leaves.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | vld_q[i];
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Vector MEM-stage controller: expands one strided load/store into per-element memory
// requests, stalls the pipeline while running and flags returning load elements.
module vec_mem_sequencer #(
    parameter int ADDR_W   = vec_mem_pkg::ADDR_W,
    parameter int VLEN_MAX = vec_mem_pkg::VLEN_MAX,
    parameter int IDX_W    = vec_mem_pkg::IDX_W,
    parameter int MEM_LAT  = vec_mem_pkg::MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [7:0]        base_addr,
    input  logic [3:0]        stride,
    input  logic [IDX_W:0]    vlen,
    input  logic              mem_ready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [IDX_W-1:0]  elem_idx,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_idx,
    output logic              done
);

    import vec_mem_pkg::*;

    localparam logic [IDX_W:0] VLEN_CAP = (IDX_W+1)'(VLEN_MAX);

    logic [1:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [IDX_W:0]    vlen_q,   vlen_d;
    logic [3:0]        stride_q, stride_d;
    logic              store_q,  store_d;

    logic [IDX_W:0] vlen_clamped;
    logic           accept;
    logic           last_elem;
    logic           lat_pending;

    assign vlen_clamped = (vlen > VLEN_CAP) ? VLEN_CAP : vlen;
    assign accept       = (state_q == ISSUE) && mem_ready;
    assign last_elem    = ({1'b0, idx_q} == vlen_q - (IDX_W+1)'(1));

    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        vlen_d   = vlen_q;
        stride_d = stride_q;
        store_d  = store_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    store_d  = is_store;
                    vlen_d   = vlen_clamped;
                    stride_d = stride;
                    if (vlen_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = {{(ADDR_W-8){1'b0}}, base_addr};
                        idx_d   = '0;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + {{(ADDR_W-4){1'b0}}, stride_q};
                    idx_d  = idx_q + IDX_W'(1);
                    if (last_elem) state_d = store_q ? DONE : DRAIN;
                end
            end
            DRAIN:   if (!lat_pending) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            idx_q    <= '0;
            vlen_q   <= '0;
            stride_q <= '0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            vlen_q   <= vlen_d;
            stride_q <= stride_d;
            store_q  <= store_d;
        end
    end

    // Accepted loads enter here; reset discards everything still in flight.
    vec_lat_pipe #(
        .DEPTH    (MEM_LAT),
        .IDX_BITS (IDX_W)
    ) u_lat_pipe (
        .clk        (clk),
        .clear_i    (rst),
        .push_vld_i (accept && !store_q),
        .push_idx_i (idx_q),
        .out_vld_o  (wb_valid),
        .out_idx_o  (wb_idx),
        .pending_o  (lat_pending)
    );

    assign busy     = (state_q != IDLE);
    assign mem_req  = (state_q == ISSUE);
    assign mem_wr   = mem_req & store_q;
    assign mem_addr = addr_q;
    assign elem_idx = idx_q;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: expected requests and writebacks are queued by the
// bench from the instruction it issues and matched as the DUT produces them.
module tb_vec_mem_sequencer;

    localparam int ADDR_W   = 32;
    localparam int VLEN_MAX = 8;
    localparam int IDX_W    = 3;
    localparam int MEM_LAT  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              is_store;
    logic [7:0]        base_addr;
    logic [3:0]        stride;
    logic [IDX_W:0]    vlen;
    logic              mem_ready;
    logic              busy;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [IDX_W-1:0]  elem_idx;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_idx;
    logic              done;

    vec_mem_sequencer #(
        .ADDR_W   (ADDR_W),
        .VLEN_MAX (VLEN_MAX),
        .IDX_W    (IDX_W),
        .MEM_LAT  (MEM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .stride    (stride),
        .vlen      (vlen),
        .mem_ready (mem_ready),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .elem_idx  (elem_idx),
        .wb_valid  (wb_valid),
        .wb_idx    (wb_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [IDX_W-1:0]  idx;
        logic              wr;
    } req_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        int               due;
    } wb_t;

    req_t exp_req[$];
    wb_t  exp_wb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = -1;
    int last_wb  = -1;
    int acc_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Checks the current cycle's outputs against the scoreboard, then advances one clock.
    task automatic step();
        req_t r;
        wb_t  w;
        if (mem_req) begin
            chk("req_expected", 32'(exp_req.size() > 0), 1);
            if (exp_req.size() > 0) begin
                r = exp_req[0];
                chk("mem_addr", mem_addr, r.addr);
                chk("elem_idx", 32'(elem_idx), 32'(r.idx));
                chk("mem_wr", 32'(mem_wr), 32'(r.wr));
                if (mem_ready) begin
                    void'(exp_req.pop_front());
                    acc_cnt++;
                    last_acc = cyc;
                    if (!r.wr) exp_wb.push_back('{idx: r.idx, due: cyc + MEM_LAT});
                end
            end
        end else begin
            chk("mem_wr_idle", 32'(mem_wr), 0);
        end
        if (exp_wb.size() > 0 && exp_wb[0].due == cyc) begin
            w = exp_wb.pop_front();
            chk("wb_valid", 32'(wb_valid), 1);
            chk("wb_idx", 32'(wb_idx), 32'(w.idx));
            last_wb = cyc;
        end else begin
            chk("wb_valid_idle", 32'(wb_valid), 0);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input logic st, input logic [7:0] b, input logic [3:0] s,
                          input logic [IDX_W:0] vl, input int stall_lo, input int stall_hi,
                          input bit restart_mid, input bit start_in_done);
        int n;
        int start_cyc;
        int exp_done;
        bit got_done;
        n = (int'(vl) > VLEN_MAX) ? VLEN_MAX : int'(vl);
        for (int i = 0; i < n; i++)
            exp_req.push_back('{addr: 32'(b) + 32'(i) * 32'(s), idx: IDX_W'(i), wr: st});
        is_store  = st;
        base_addr = b;
        stride    = s;
        vlen      = vl;
        start     = 1'b1;
        mem_ready = 1'b1;
        start_cyc = cyc;
        step();
        // Scramble the instruction inputs: the DUT must be working from its latched copy.
        start     = 1'b0;
        is_store  = ~st;
        base_addr = 8'hA5;
        stride    = 4'd7;
        vlen      = 1;
        got_done  = 1'b0;
        for (int k = 1; k <= 60 && !got_done; k++) begin
            chk("busy", 32'(busy), 1);
            if (done) begin
                got_done = 1'b1;
                exp_done = (n == 0) ? start_cyc + 1 : (st ? last_acc + 1 : last_wb + 1);
                chk("done_cycle", cyc, exp_done);
            end
            mem_ready = !(k >= stall_lo && k <= stall_hi);
            start     = (restart_mid && k == 3) || (start_in_done && got_done);
            step();
        end
        chk("done_seen", 32'(got_done), 1);
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        step();
        chk("busy_idle", 32'(busy), 0);
        chk("reqs_outstanding", exp_req.size(), 0);
        chk("wb_outstanding", exp_wb.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_elem_idx"}, 32'(elem_idx), 0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 0);
        chk({tag, "_wb_idx"}, 32'(wb_idx), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_store  = 1'b0;
        base_addr = '0;
        stride    = '0;
        vlen      = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Load, unit stride, always ready.
        run_op(1'b0, 8'h10, 4'd1, 4'd4, 0, -1, 1'b0, 1'b0);
        // Store crossing the 8-bit base range; start held during DONE must be ignored.
        run_op(1'b1, 8'hFE, 4'd3, 4'd3, 0, -1, 1'b0, 1'b1);
        // Load with memory back-pressure on ISSUE cycles 2-3.
        run_op(1'b0, 8'h40, 4'd4, 4'd3, 2, 3, 1'b0, 1'b0);
        // Zero-length instruction.
        run_op(1'b0, 8'h33, 4'd1, 4'd0, 0, -1, 1'b0, 1'b0);
        // Over-long vector clamps to VLEN_MAX; a second start mid-ISSUE is ignored.
        run_op(1'b0, 8'h80, 4'd2, 4'd12, 0, -1, 1'b1, 1'b0);
        // Zero stride store.
        run_op(1'b1, 8'h07, 4'd0, 4'd2, 0, -1, 1'b0, 1'b0);

        // Reset after the third accepted element of an 8-element load.
        for (int i = 0; i < 8; i++)
            exp_req.push_back('{addr: 32'h20 + 32'(i) * 32'd2, idx: IDX_W'(i), wr: 1'b0});
        is_store  = 1'b0;
        base_addr = 8'h20;
        stride    = 4'd2;
        vlen      = 4'd8;
        start     = 1'b1;
        mem_ready = 1'b1;
        step();
        start   = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 20 && acc_cnt < 3; k++) step();
        chk("accepts_before_reset", acc_cnt, 3);
        rst       = 1'b1;
        mem_ready = 1'b0;
        step();
        exp_req.delete();
        exp_wb.delete();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        mem_ready = 1'b1;
        for (int k = 0; k < MEM_LAT + 2; k++) begin
            chk("post_reset_busy", 32'(busy), 0);
            chk("post_reset_done", 32'(done), 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
